lfsr_box_picker: RTL
====================

// Module: lfsr_box_picker
// PURPOSE
//  Parametrised pseudo-random target selector for the whack-a-box game. A WIDTH-bit
//  Fibonacci LFSR free-runs every cycle; on a request it draws a uniformly distributed box
//  index in [0, NUM_BOXES-1] by rejection sampling, optionally never repeating the last box.
//  Reseeding from a free-running counter supplies human-timed entropy. The box index feeds
//  the game controller and the hex display path.
// PARAMETERS
//  WIDTH        8      LFSR width, >=3
//  TAPS         8'hB8  feedback mask: fb = ^(lfsr & TAPS); default gives period 255
//  SEED_DEFAULT 8'h01  LFSR value on reset; must be nonzero
//  NUM_BOXES    4      number of targets, 2..2**WIDTH
//  NO_REPEAT    1      1: a draw never equals the previous box
//  MAX_TRIES    8      rejected draws allowed before the fallback pick is used
// PORTS
//  CLOCK_50     in  1      system clock, 50 MHz
//  reset_signal in  1      asynchronous, active-high reset
//  reseed       in  1      1-cycle pulse: load LFSR from free-running counter
//  pick_req     in  1      1-cycle pulse: request a new box
//  busy         out 1      draw in progress; pick_req ignored while high
//  pick_valid   out 1      1-cycle pulse: box is the new pick
//  box          out BOX_W  current pick, held until the next pick_valid; BOX_W = $clog2(NUM_BOXES)
//  lfsr_state   out WIDTH  raw LFSR value (debug/verification)
// BEHAVIOUR
//  Reset: lfsr=SEED_DEFAULT, counter=0, state=IDLE, busy=0, pick_valid=0, box=0, last_valid=0.
//  LFSR: each cycle lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}; all-zero state is illegal:
//   if lfsr==0, next value is 1.
//  Counter: WIDTH-bit free-running, +1 every cycle, wraps 2**WIDTH-1 -> 0.
//  Reseed: lfsr <= counter (counter==0 -> load 1); reseed overrides the step that cycle;
//   does not change FSM state; an in-flight draw continues using the new sequence.
//  FSM states IDLE, DRAW, DONE:
//   IDLE: pick_req=1 -> DRAW, tries=0, busy=1 next cycle.
//   DRAW: cand = lfsr[BOX_W-1:0]. Accept if cand < NUM_BOXES and not
//    (NO_REPEAT && last_valid && cand==box). Accept -> box<=cand, DONE.
//    Reject -> tries+1, stay DRAW (LFSR has advanced). tries==MAX_TRIES-1 and reject ->
//    fallback box<=(box+1) mod NUM_BOXES (box itself if NO_REPEAT=0 and cand>=NUM_BOXES
//    would be unusual: fallback always (box+1) mod NUM_BOXES), DONE.
//   DONE: pick_valid=1 for exactly this cycle, last_valid<=1, busy=0 -> IDLE.
//  Latency: pick_req at cycle t -> pick_valid at t+2 (first draw accepted), at most
//   t+1+MAX_TRIES. busy high from t+1 through the cycle before pick_valid.
//  pick_req while busy or in DONE: dropped, no queuing. pick_req and reseed same cycle: both act.
//  Reset mid-draw: FSM to IDLE immediately, no pick_valid, box=0, last_valid=0.
//  NUM_BOXES a power of two: no rejection for range, only for NO_REPEAT.
// STRUCTURE
//  lfsr_pkg: FSM state enum (IDLE/DRAW/DONE), function default_taps(width) for 3..16,
//   function clog2 helper.
//  Sub-module lfsr_core (WIDTH, TAPS): step/load/zero-lockup logic, load port for reseed.
//  Top holds counter, FSM, tries counter, accept/reject compare, box register.
// TESTING
//  1 Reset, no reseed -> lfsr_state sequence 01,02,04,08,11 on successive cycles;
//    period exactly 255, never 00.
//  2 reseed when counter==8'h00 -> lfsr_state=8'h01 next cycle; counter==8'h5A -> 8'h5A.
//  3 NUM_BOXES=4, NO_REPEAT=1, 1000 picks -> no two consecutive boxes equal; each box 200..300.
//  4 NUM_BOXES=3 -> box never 3; pick_valid 2..1+MAX_TRIES cycles after pick_req; 1-cycle pulse.
//  5 pick_req pulsed while busy -> ignored, exactly one pick_valid per accepted request.
//  6 reset_signal asserted while busy -> busy=0, pick_valid=0, box=0 same cycle;
//    next pick after release may equal any box (last_valid cleared).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR box picker.
// FSM encoding, default tap table and a constant-safe clog2.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Maximal-length masks for the shift-left Fibonacci form used here
    function automatic logic [15:0] default_taps(input int width);
        logic [15:0] t;
        case (width)
            3:       t = 16'h0006;
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h00B8;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous load.
// The all-zero lock-up state is never entered: it is replaced by 1.
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             CLOCK_50,
    input  logic             reset_signal,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_lfsr
);

    localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_next;

    assign w_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign w_pre  = i_load ? i_load_val : w_step;
    assign w_next = (w_pre == '0) ? L_ONE : w_pre;

    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) r_lfsr <= SEED;
        else              r_lfsr <= w_next;
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/lfsr_box_picker.sv
// Pseudo-random target selector: rejection-sampled box index from a
// free-running LFSR, optionally never repeating the previous box.
module lfsr_box_picker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01,
    parameter int               NUM_BOXES    = 4,
    parameter int               NO_REPEAT    = 1,
    parameter int               MAX_TRIES    = 8,
    localparam int              BOX_W        = clog2(NUM_BOXES)
) (
    input  logic             CLOCK_50,
    input  logic             reset_signal,
    input  logic             reseed,
    input  logic             pick_req,
    output logic             busy,
    output logic             pick_valid,
    output logic [BOX_W-1:0] box,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int               TRY_W   = clog2(MAX_TRIES + 1);
    localparam logic [BOX_W:0]   L_NB    = (BOX_W + 1)'(NUM_BOXES);
    localparam logic [TRY_W-1:0] L_LAST  = TRY_W'(MAX_TRIES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [TRY_W-1:0] r_tries;
    logic [TRY_W-1:0] w_tries_nxt;
    logic [BOX_W-1:0] r_box;
    logic [BOX_W-1:0] w_box_nxt;
    logic             r_last_valid;
    logic             w_last_nxt;
    logic [WIDTH-1:0] w_lfsr;
    logic [BOX_W-1:0] w_cand;
    logic [BOX_W:0]   w_box_inc;
    logic [BOX_W-1:0] w_fallback;
    logic             w_accept;
    logic             w_repeat;

    // Counter value 0 is mapped to 1 inside the core on load
    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED_DEFAULT)
    ) u_core (
        .CLOCK_50     (CLOCK_50),
        .reset_signal (reset_signal),
        .i_load       (reseed),
        .i_load_val   (r_cnt),
        .o_lfsr       (w_lfsr)
    );

    assign w_cand     = w_lfsr[BOX_W-1:0];
    assign w_repeat   = (NO_REPEAT != 0) && r_last_valid && (w_cand == r_box);
    assign w_accept   = ({1'b0, w_cand} < L_NB) && !w_repeat;
    assign w_box_inc  = {1'b0, r_box} + 1'b1;
    assign w_fallback = (w_box_inc == L_NB) ? '0 : w_box_inc[BOX_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        w_box_nxt   = r_box;
        w_last_nxt  = r_last_valid;
        busy        = 1'b0;
        pick_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (pick_req) begin
                    w_state_nxt = DRAW;
                    w_tries_nxt = '0;
                end
            end
            DRAW: begin
                busy = 1'b1;
                if (w_accept) begin
                    w_box_nxt   = w_cand;
                    w_state_nxt = DONE;
                end else if (r_tries == L_LAST) begin
                    w_box_nxt   = w_fallback;
                    w_state_nxt = DONE;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
            DONE: begin
                pick_valid  = 1'b1;
                w_last_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tries      <= '0;
            r_box        <= '0;
            r_last_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= r_cnt + 1'b1;
            r_tries      <= w_tries_nxt;
            r_box        <= w_box_nxt;
            r_last_valid <= w_last_nxt;
        end
    end

    assign box        = r_box;
    assign lfsr_state = w_lfsr;

endmodule
